// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the buzzer music scheduler: FSM state encoding,
// default requester/select widths and a highest-set-bit index function.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_SEL_W = 2;

    // Index of the highest set bit, 0 when the vector is empty.
    function automatic int highest_set(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/buzzer_prio_enc.sv
// Combinational highest-index priority encoder: index of the top set bit of
// vec plus a valid flag when any bit is set.
module buzzer_prio_enc
    import buzzer_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [NREQ-1:0]  vec,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = SEL_W'(highest_set(32'(vec)));
        valid = |vec;
    end

endmodule

// File: rtl/buzzer_music_sched.sv
// Buzzer music scheduler: sticky request latching, priority grant and
// start/play/gap sequencing for the single buzzer player.
// Optional build macro BUZZER_PREEMPT_EN: a higher pending request ends the
// current song early (the preempted song is not re-queued).
module buzzer_music_sched
    import buzzer_pkg::*;
#(
    parameter int          NREQ       = DEF_NREQ,
    parameter int          SEL_W      = DEF_SEL_W,
    parameter int          GAP_CYCLES = 16,
    parameter logic [23:0] MAX_PLAY   = 24'hFFFFFF
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    input  logic             music_done,
    output logic [SEL_W-1:0] music_select,
    output logic             music_start,
    output logic             busy,
    output logic [NREQ-1:0]  pending,
    output logic             timeout
);

    localparam int               GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [23:0]      PLAY_LAST = MAX_PLAY - 24'd1;

    state_t            state;
    logic [23:0]       play_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [SEL_W-1:0]  win_idx;
    logic              win_vld;
    logic              do_grant;
    logic              preempt;
    logic              play_end;
    logic              play_expired;
    logic [NREQ-1:0]   grant_clr;

    buzzer_prio_enc #(.NREQ(NREQ), .SEL_W(SEL_W)) u_enc (
        .vec   (pending),
        .idx   (win_idx),
        .valid (win_vld)
    );

    assign do_grant = (state == ST_IDLE) && enable && win_vld;

`ifdef BUZZER_PREEMPT_EN
    assign preempt = win_vld && (win_idx > music_select);
`else
    assign preempt = 1'b0;
`endif

    assign play_expired = (play_cnt == PLAY_LAST);
    assign play_end     = music_done || play_expired || !enable || preempt;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        grant_clr = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_clr[i] = do_grant && (win_idx == SEL_W'(i));
        end
    end

    // New requests win over the grant clear of the same index.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) pending <= '0;
        else          pending <= (pending & ~grant_clr) | req;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= ST_IDLE;
            music_select <= '0;
            music_start  <= 1'b0;
            timeout      <= 1'b0;
            play_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (do_grant) begin
                        music_select <= win_idx;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (!enable) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        music_start <= 1'b1;
                        play_cnt    <= '0;
                        state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play_end) begin
                        // done takes precedence: no timeout pulse when both coincide
                        timeout     <= play_expired && !music_done;
                        music_start <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end else begin
                        play_cnt <= play_cnt + 24'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state   <= ST_IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_music_sched.sv
// Self-checking bench for buzzer_music_sched: directed scenarios plus a
// randomized run compared against a timestamp-based behavioural model.
module tb_buzzer_music_sched;

    localparam int GAP      = 16;
    localparam int MAXP     = 100;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       enable;
    logic [3:0] req;
    logic       music_done;
    logic [1:0] music_select;
    logic       music_start;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    buzzer_music_sched #(
        .NREQ(4), .SEL_W(2), .GAP_CYCLES(GAP), .MAX_PLAY(24'(MAXP))
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .enable       (enable),
        .req          (req),
        .music_done   (music_done),
        .music_select (music_select),
        .music_start  (music_start),
        .busy         (busy),
        .pending      (pending),
        .timeout      (timeout)
    );

    always #5 HCLK = ~HCLK;

    // Behavioural model: phases with absolute cycle deadlines.
    longint   cyc;
    int       m_phase;      // 0 idle, 1 armed, 2 playing, 3 silent
    bit [3:0] m_pend;
    bit [1:0] m_sel;
    bit       m_start;
    bit       m_to;
    longint   play_begin;
    longint   gap_end;

    task automatic model_reset();
        cyc = 0; m_phase = 0; m_pend = 0; m_sel = 0; m_start = 0; m_to = 0;
        play_begin = 0; gap_end = 0;
    endtask

    task automatic model_step();
        bit [3:0] gmask;
        bit       stop;
        gmask = 0;
        m_to  = 0;
        cyc++;
        case (m_phase)
            0: if (enable && m_pend != 0) begin
                for (int i = 0; i < 4; i++) if (m_pend[i]) m_sel = 2'(i);
                gmask[m_sel] = 1'b1;
                m_phase = 1;
            end
            1: if (!enable) begin
                m_phase = 3; gap_end = cyc + GAP;
            end else begin
                m_start = 1; m_phase = 2; play_begin = cyc + 1;
            end
            2: begin
                stop = music_done || !enable;
                if (!music_done && (cyc - play_begin + 1 == MAXP)) begin
                    m_to = 1; stop = 1;
                end
`ifdef BUZZER_PREEMPT_EN
                for (int i = 0; i < 4; i++) if (m_pend[i] && i > int'(m_sel)) stop = 1;
`endif
                if (stop) begin
                    m_start = 0; m_phase = 3; gap_end = cyc + GAP;
                end
            end
            default: if (cyc == gap_end) m_phase = 0;
        endcase
        m_pend = (m_pend & ~gmask) | req;
    endtask

    task automatic tick();
        model_step();
        @(negedge HCLK);
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v; tick(); req = 4'b0;
    endtask

    task automatic pulse_done();
        music_done = 1'b1; tick(); music_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin n++; tick(); end
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
        checks++;
    endtask

    task automatic test_reset();
        checks++;
        if ({music_select, music_start, busy, pending, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%0d start=%0b busy=%0b pend=%b to=%0b, required all 0",
                     music_select, music_start, busy, pending, timeout);
        end
        HRESETn = 1'b1;
        enable  = 1'b1;
        pulse_req(4'b0100);
        pulse_req(4'b0001);
        tick(); tick();
        checks++;
        if (music_start !== 1'b1 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL reset_setup: start=%0b pend=%b, required 1 0001", music_start, pending);
        end
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({music_select, music_start, busy, pending, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_midplay: sel=%0d start=%0b busy=%0b pend=%b to=%0b, required all 0",
                     music_select, music_start, busy, pending, timeout);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || music_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b start=%0b, required 0 0", busy, music_start);
        end
    endtask

    task automatic test_single();
        int lo;
        bit bad;
        pulse_req(4'b0010);
        checks++;
        if (pending !== 4'b0010 || music_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pend=%b start=%0b busy=%0b, required 0010 0 0",
                     pending, music_start, busy);
        end
        tick();
        checks++;
        if (music_select !== 2'd1 || busy !== 1'b1 || pending !== 4'b0 || music_start !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: sel=%0d busy=%0b pend=%b start=%0b, required 1 1 0000 0",
                     music_select, busy, pending, music_start);
        end
        tick();
        checks++;
        if (music_start !== 1'b1) begin
            errors++;
            $display("FAIL single_start: start=%0b, required 1", music_start);
        end
        repeat (5) tick();
        pulse_done();
        lo = 0; bad = 0;
        while (busy && lo < 40) begin
            if (music_start) bad = 1;
            lo++; tick();
        end
        checks++;
        if (lo != GAP || bad) begin
            errors++;
            $display("FAIL single_gap: busy cycles=%0d start_seen=%0b, required %0d 0", lo, bad, GAP);
        end
    endtask

    task automatic test_priority();
        int n;
        pulse_req(4'b0101);
        tick();
        checks++;
        if (music_select !== 2'd2 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL prio_first: sel=%0d pend=%b, required 2 0001", music_select, pending);
        end
        tick();
        repeat (10) tick();
        pulse_done();
        n = 0;
        while (!music_start && n < 60) begin n++; tick(); end
        checks++;
        if (n != GAP + 2 || music_select !== 2'd0) begin
            errors++;
            $display("FAIL prio_second: low cycles=%0d sel=%0d, required %0d 0", n, music_select, GAP + 2);
        end
        pulse_done();
        wait_idle();
    endtask

    task automatic test_timeout();
        int n;
        pulse_req(4'b0001);
        tick(); tick();
        n = 0;
        while (music_start && n < 300) begin
            if (timeout) begin
                errors++; checks++;
                $display("FAIL timeout_early: timeout=1 at play cycle %0d, required 0", n);
            end
            n++; tick();
        end
        checks++;
        if (n != MAXP || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: play cycles=%0d timeout=%0b, required %0d 1", n, timeout, MAXP);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: timeout=%0b, required 0", timeout);
        end
        wait_idle();
    endtask

    task automatic test_disable();
        pulse_req(4'b1000);
        tick(); tick();
        pulse_req(4'b1000);
        enable = 1'b0;
        tick();
        checks++;
        if (music_start !== 1'b0 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL disable_stop: start=%0b pend=%b, required 0 1000", music_start, pending);
        end
        repeat (30) tick();
        checks++;
        if (busy !== 1'b0 || music_start !== 1'b0 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL disable_hold: busy=%0b start=%0b pend=%b, required 0 0 1000",
                     busy, music_start, pending);
        end
        enable = 1'b1;
        tick(); tick();
        checks++;
        if (music_start !== 1'b1 || music_select !== 2'd3 || pending !== 4'b0) begin
            errors++;
            $display("FAIL disable_resume: start=%0b sel=%0d pend=%b, required 1 3 0000",
                     music_start, music_select, pending);
        end
        pulse_done();
        wait_idle();
    endtask

    task automatic test_preempt();
        int n;
        pulse_req(4'b0010);
        tick(); tick();
        pulse_req(4'b1000);
        tick();
`ifdef BUZZER_PREEMPT_EN
        checks++;
        if (music_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL preempt_cut: start=%0b busy=%0b, required 0 1", music_start, busy);
        end
`else
        repeat (10) tick();
        checks++;
        if (music_start !== 1'b1 || music_select !== 2'd1) begin
            errors++;
            $display("FAIL preempt_none: start=%0b sel=%0d, required 1 1", music_start, music_select);
        end
        pulse_done();
`endif
        n = 0;
        while (!music_start && n < 60) begin n++; tick(); end
        checks++;
        if (music_start !== 1'b1 || music_select !== 2'd3) begin
            errors++;
            $display("FAIL preempt_next: start=%0b sel=%0d, required 1 3", music_start, music_select);
        end
        pulse_done();
        wait_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 39) == 0);
            music_done = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            tick();
            checks++;
            if (music_select !== m_sel || music_start !== m_start || busy !== (m_phase != 0) ||
                pending !== m_pend || timeout !== m_to) begin
                errors++;
                $display("FAIL random c=%0d: sel=%0d start=%0b busy=%0b pend=%b to=%0b, required %0d %0b %0b %b %0b",
                         c, music_select, music_start, busy, pending, timeout,
                         m_sel, m_start, (m_phase != 0), m_pend, m_to);
            end
        end
        req = 4'b0; music_done = 1'b0; enable = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0; enable = 1'b0; req = 4'b0; music_done = 1'b0;
        model_reset();
        repeat (3) @(negedge HCLK);
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_disable();
        test_preempt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
